// File: rtl/fsm_pkg.sv
// Shared encodings for the serial pattern/run detector: FSM states and mode selects.
`timescale 1ns/1ps
package fsm_pkg;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } state_e;

  localparam logic MODE_PATTERN = 1'b0;
  localparam logic MODE_RUN     = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a clear that takes precedence over increment.
`timescale 1ns/1ps
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear wins over increment; increment stops at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fsm_pattern_detector.sv
// Serial detector: flags a programmable LENGTH-bit pattern or a run of LENGTH equal bits,
// with overlapping/non-overlapping detection and a saturating match counter.
`timescale 1ns/1ps
module fsm_pattern_detector
  import fsm_pkg::*;
#(
  parameter int                LENGTH          = 4,
  parameter int                COUNT_WIDTH     = 8,
  parameter logic [LENGTH-1:0] DEFAULT_PATTERN = LENGTH'(4'b1011)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         w,
  input  logic                         enable,
  input  logic                         mode,
  input  logic                         overlap,
  input  logic                         load,
  input  logic [LENGTH-1:0]            pattern_in,
  input  logic                         clear,
  output logic                         z,
  output logic [COUNT_WIDTH-1:0]       match_count,
  output logic [$clog2(LENGTH+1)-1:0]  fill
);

  localparam int             FW   = $clog2(LENGTH + 1);
  localparam logic [FW-1:0]  FULL = FW'(LENGTH);

  logic [LENGTH-1:0] pattern_q, pattern_d;
  logic [LENGTH-1:0] history_q, history_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [FW-1:0]     fill_inc;
  logic              last_q, last_d;
  state_e            state_q;
  logic              z_q;
  logic              match;
  logic              arm_d;

  assign fill_inc = (fill_q == FULL) ? FULL : fill_q + 1'b1;

  // Next-state datapath; load discards w and wipes the history, enable=0 freezes everything.
  always_comb begin
    pattern_d = pattern_q;
    history_d = history_q;
    fill_d    = fill_q;
    last_d    = last_q;
    match     = 1'b0;
    if (load) begin
      pattern_d = pattern_in;
      history_d = '0;
      fill_d    = '0;
    end else if (enable) begin
      if (mode == MODE_RUN) begin
        if ((w == last_q) && (fill_q != '0)) begin
          fill_d = fill_inc;
        end else begin
          fill_d = FW'(1);
          last_d = w;
        end
        match = (fill_d == FULL);
      end else begin
        history_d = {history_q[LENGTH-2:0], w};
        fill_d    = fill_inc;
        match     = (fill_d == FULL) && (history_d == pattern_q);
      end
      if (match && !overlap) begin
        fill_d = '0;
      end
    end
  end

  assign arm_d = (mode == MODE_PATTERN) ? (fill_d == FULL) : (fill_d != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pattern_q <= DEFAULT_PATTERN;
      history_q <= '0;
      fill_q    <= '0;
      last_q    <= 1'b0;
      state_q   <= S_FILL;
      z_q       <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      history_q <= history_d;
      fill_q    <= fill_d;
      last_q    <= last_d;
      z_q       <= match;
      if (load || enable) begin
        case (state_q)
          S_FILL:  if (arm_d)  state_q <= S_ARMED;
          S_ARMED: if (!arm_d) state_q <= S_FILL;
        endcase
      end
    end
  end

  sat_counter #(
    .WIDTH(COUNT_WIDTH)
  ) u_count (
    .clock  (clock),
    .reset  (reset),
    .inc_i  (match),
    .clr_i  (clear),
    .count_o(match_count)
  );

  assign z    = z_q;
  assign fill = fill_q;

endmodule

// File: tb/tb_fsm_pattern_detector.sv
// Directed bench for fsm_pattern_detector (LENGTH=4, default pattern 1011).
`timescale 1ns/1ps
module tb_fsm_pattern_detector;

  logic       clock;
  logic       reset;
  logic       w;
  logic       enable;
  logic       mode;
  logic       overlap;
  logic       load;
  logic [3:0] pattern_in;
  logic       clear;
  logic       z;
  logic [7:0] match_count;
  logic [2:0] fill;

  int total = 0;
  int bad   = 0;

  fsm_pattern_detector #(
    .LENGTH(4),
    .COUNT_WIDTH(8),
    .DEFAULT_PATTERN(4'b1011)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .w          (w),
    .enable     (enable),
    .mode       (mode),
    .overlap    (overlap),
    .load       (load),
    .pattern_in (pattern_in),
    .clear      (clear),
    .z          (z),
    .match_count(match_count),
    .fill       (fill)
  );

  // Period-2 clock source.
  initial clock = 1'b0;
  always #1 clock = ~clock;

  // Sends n bits, bits[n-1] first, recording z after each edge into the same bit position.
  task automatic sendBits(input logic [15:0] bits, input int n, output logic [15:0] zs);
    zs = '0;
    for (int i = n - 1; i >= 0; i--) begin
      w      = bits[i];
      enable = 1'b1;
      @(posedge clock);
      @(negedge clock);
      zs[i] = z;
    end
    enable = 1'b0;
  endtask

  task automatic doReset();
    enable = 1'b0; load = 1'b0; clear = 1'b0; w = 1'b0;
    reset  = 1'b1;
    #0.5;
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; w = 1'b0; enable = 1'b0; mode = 1'b0; overlap = 1'b0;
    load = 1'b0; pattern_in = 4'b0000; clear = 1'b0;
    #0.3 reset = 1'b1;
    #0.2;
    total++; if (z !== 1'b0) begin bad++; $display("[TB] FAIL reset_z got=%b want=0", z); end
    total++; if (match_count !== 8'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", match_count); end
    total++; if (fill !== 3'd0) begin bad++; $display("[TB] FAIL reset_fill got=%0d want=0", fill); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_pattern_overlap();
    logic [15:0] zs;
    doReset(); mode = 1'b0; overlap = 1'b1;
    sendBits(16'b1011011, 7, zs);
    total++; if (zs !== 16'b0001001) begin bad++; $display("[TB] FAIL pat_ovl_z got=%b want=%b", zs[6:0], 7'b0001001); end
    total++; if (match_count !== 8'd2) begin bad++; $display("[TB] FAIL pat_ovl_count got=%0d want=2", match_count); end
    total++; if (fill !== 3'd4) begin bad++; $display("[TB] FAIL pat_ovl_fill got=%0d want=4", fill); end
  endtask

  task automatic test_pattern_nonoverlap();
    logic [15:0] zs;
    doReset(); mode = 1'b0; overlap = 1'b0;
    sendBits(16'b1011011, 7, zs);
    total++; if (zs !== 16'b0001000) begin bad++; $display("[TB] FAIL pat_novl_z got=%b want=%b", zs[6:0], 7'b0001000); end
    total++; if (match_count !== 8'd1) begin bad++; $display("[TB] FAIL pat_novl_count got=%0d want=1", match_count); end
    total++; if (fill !== 3'd3) begin bad++; $display("[TB] FAIL pat_novl_fill got=%0d want=3", fill); end
  endtask

  task automatic test_run_overlap();
    logic [15:0] zs;
    doReset(); mode = 1'b1; overlap = 1'b1;
    sendBits(16'b111110, 6, zs);
    total++; if (zs !== 16'b000110) begin bad++; $display("[TB] FAIL run_ovl_z got=%b want=%b", zs[5:0], 6'b000110); end
    total++; if (match_count !== 8'd2) begin bad++; $display("[TB] FAIL run_ovl_count got=%0d want=2", match_count); end
    total++; if (fill !== 3'd1) begin bad++; $display("[TB] FAIL run_ovl_fill got=%0d want=1", fill); end
  endtask

  task automatic test_run_nonoverlap();
    logic [15:0] zs;
    doReset(); mode = 1'b1; overlap = 1'b0;
    sendBits(16'b11111, 5, zs);
    total++; if (zs !== 16'b00010) begin bad++; $display("[TB] FAIL run_novl_z got=%b want=%b", zs[4:0], 5'b00010); end
    total++; if (match_count !== 8'd1) begin bad++; $display("[TB] FAIL run_novl_count got=%0d want=1", match_count); end
    total++; if (fill !== 3'd1) begin bad++; $display("[TB] FAIL run_novl_fill got=%0d want=1", fill); end
  endtask

  task automatic test_enable_hold();
    logic [15:0] zs;
    doReset(); mode = 1'b0; overlap = 1'b1;
    sendBits(16'b1011, 4, zs);
    total++; if (zs !== 16'b0001) begin bad++; $display("[TB] FAIL hold_first_z got=%b want=0001", zs[3:0]); end
    w = 1'b0; enable = 1'b0;
    @(posedge clock); @(negedge clock);
    total++; if (z !== 1'b0) begin bad++; $display("[TB] FAIL hold_z_drop got=%b want=0", z); end
    total++; if (fill !== 3'd4) begin bad++; $display("[TB] FAIL hold_fill got=%0d want=4", fill); end
    total++; if (match_count !== 8'd1) begin bad++; $display("[TB] FAIL hold_count got=%0d want=1", match_count); end
    sendBits(16'b011, 3, zs);
    total++; if (zs !== 16'b001) begin bad++; $display("[TB] FAIL hold_resume_z got=%b want=001", zs[2:0]); end
    total++; if (match_count !== 8'd2) begin bad++; $display("[TB] FAIL hold_resume_count got=%0d want=2", match_count); end
  endtask

  task automatic test_load();
    logic [15:0] zs;
    doReset(); mode = 1'b0; overlap = 1'b1;
    sendBits(16'b10, 2, zs);
    load = 1'b1; enable = 1'b1; w = 1'b1; pattern_in = 4'b0110;
    @(posedge clock); @(negedge clock);
    load = 1'b0; enable = 1'b0;
    total++; if (z !== 1'b0) begin bad++; $display("[TB] FAIL load_z got=%b want=0", z); end
    total++; if (fill !== 3'd0) begin bad++; $display("[TB] FAIL load_fill got=%0d want=0", fill); end
    sendBits(16'b0110, 4, zs);
    total++; if (zs !== 16'b0001) begin bad++; $display("[TB] FAIL load_new_z got=%b want=0001", zs[3:0]); end
    total++; if (match_count !== 8'd1) begin bad++; $display("[TB] FAIL load_count got=%0d want=1", match_count); end
    sendBits(16'b1011, 4, zs);
    total++; if (zs !== 16'b0000) begin bad++; $display("[TB] FAIL load_old_pattern_z got=%b want=0000", zs[3:0]); end
  endtask

  task automatic test_saturate();
    logic [15:0] zs;
    doReset(); mode = 1'b1; overlap = 1'b1;
    for (int i = 0; i < 257; i++) sendBits(16'h0001, 1, zs);
    total++; if (match_count !== 8'd254) begin bad++; $display("[TB] FAIL sat_254 got=%0d want=254", match_count); end
    sendBits(16'h0001, 1, zs);
    total++; if (match_count !== 8'd255) begin bad++; $display("[TB] FAIL sat_255 got=%0d want=255", match_count); end
    sendBits(16'h0003, 2, zs);
    total++; if (match_count !== 8'd255) begin bad++; $display("[TB] FAIL sat_hold got=%0d want=255", match_count); end
    total++; if (zs !== 16'b11) begin bad++; $display("[TB] FAIL sat_z got=%b want=11", zs[1:0]); end
  endtask

  task automatic test_clear_on_match();
    logic [15:0] zs;
    clear = 1'b1;
    sendBits(16'h0001, 1, zs);
    clear = 1'b0;
    total++; if (zs[0] !== 1'b1) begin bad++; $display("[TB] FAIL clear_z got=%b want=1", zs[0]); end
    total++; if (match_count !== 8'd0) begin bad++; $display("[TB] FAIL clear_count got=%0d want=0", match_count); end
    sendBits(16'h0001, 1, zs);
    total++; if (match_count !== 8'd1) begin bad++; $display("[TB] FAIL clear_recount got=%0d want=1", match_count); end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] zs;
    doReset(); mode = 1'b0; overlap = 1'b1;
    sendBits(16'b101110, 6, zs);
    total++; if (match_count !== 8'd1) begin bad++; $display("[TB] FAIL mid_pre_count got=%0d want=1", match_count); end
    reset = 1'b1;
    #0.5;
    total++; if (z !== 1'b0) begin bad++; $display("[TB] FAIL mid_z got=%b want=0", z); end
    total++; if (match_count !== 8'd0) begin bad++; $display("[TB] FAIL mid_count got=%0d want=0", match_count); end
    total++; if (fill !== 3'd0) begin bad++; $display("[TB] FAIL mid_fill got=%0d want=0", fill); end
    #0.2 reset = 1'b0;
    sendBits(16'b11011, 5, zs);
    total++; if (zs !== 16'b00001) begin bad++; $display("[TB] FAIL mid_after_z got=%b want=00001", zs[4:0]); end
    total++; if (match_count !== 8'd1) begin bad++; $display("[TB] FAIL mid_after_count got=%0d want=1", match_count); end
  endtask

  initial begin
    test_reset();
    test_pattern_overlap();
    test_pattern_nonoverlap();
    test_run_overlap();
    test_run_nonoverlap();
    test_enable_hold();
    test_load();
    test_saturate();
    test_clear_on_match();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
